// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: operation codes, execute
// state encoding and the default datapath width.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLT = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } exec_state_e;

    // True for the three shift opcodes.
    function automatic logic is_shift_op(input logic [2:0] code);
        return (code == ALU_SRA) || (code == ALU_SLL) || (code == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_execute_stage_if.sv
// Operation/result bus of the ALU execute stage.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The sender holds valid and its payload stable until that edge;
// ready may be computed from the receiver's state and never depends on valid.
// Upstream side: in_valid/in_ready with alu_control, sub, cmp_unsigned,
// op_a, op_b, rd_in. Downstream side: out_valid/out_ready with result, zero,
// rd_out.
interface alu_execute_stage_if #(parameter int XLEN = alu_pkg::XLEN);

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      alu_control;
    logic            sub;
    logic            cmp_unsigned;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [4:0]      rd_out;

    // Environment side: issues operations and consumes results.
    modport master (
        output in_valid, alu_control, sub, cmp_unsigned, op_a, op_b, rd_in, out_ready,
        input  in_ready, out_valid, result, zero, rd_out
    );

    // Execute stage side.
    modport slave (
        input  in_valid, alu_control, sub, cmp_unsigned, op_a, op_b, rd_in, out_ready,
        output in_ready, out_valid, result, zero, rd_out
    );

endinterface

// File: rtl/alu_shift_unit.sv
// Shift datapath of the execute stage. Default build: iterative shifter that
// moves one bit per cycle while the top level sits in SHIFT. With
// ALU_FAST_SHIFT_EN defined: a combinational barrel shifter, so every shift
// completes immediately and no iteration is ever requested.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,        // start an iterative shift
    input  logic            advance,     // perform one 1-bit step
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand,
    input  logic [4:0]      shamt,
    output logic            need_iter,   // this shift must go through SHIFT
    output logic [XLEN-1:0] imm_value,   // result when no iteration is needed
    output logic [XLEN-1:0] step_value,  // operand after the current step
    output logic            last_step    // current step produces the result
);

`ifdef ALU_FAST_SHIFT_EN

    logic unused_fast;
    assign unused_fast = ^{clk, rst, load, advance};

    assign need_iter  = 1'b0;
    assign step_value = '0;
    assign last_step  = 1'b0;

    // Whole shift in one pass.
    always_comb begin
        imm_value = operand;
        case (op)
            ALU_SLL: imm_value = operand << shamt;
            ALU_SRL: imm_value = operand >> shamt;
            ALU_SRA: imm_value = $unsigned($signed(operand) >>> shamt);
            default: imm_value = operand;
        endcase
    end

`else

    logic [XLEN-1:0] shift_reg;
    logic [4:0]      count;
    logic [2:0]      op_q;

    // A zero shift amount leaves the operand untouched.
    assign need_iter = (shamt != 5'd0);
    assign imm_value = operand;
    assign last_step = (count == 5'd1);

    // One-bit step in the latched direction; sra replicates the sign bit.
    always_comb begin
        step_value = shift_reg;
        case (op_q)
            ALU_SLL: step_value = {shift_reg[XLEN-2:0], 1'b0};
            ALU_SRL: step_value = {1'b0, shift_reg[XLEN-1:1]};
            ALU_SRA: step_value = {shift_reg[XLEN-1], shift_reg[XLEN-1:1]};
            default: step_value = shift_reg;
        endcase
    end

    // Latch operand/amount/direction on start, then step and count down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            count     <= 5'd0;
            op_q      <= ALU_ADD;
        end else if (load) begin
            shift_reg <= operand;
            count     <= shamt;
            op_q      <= op;
        end else if (advance) begin
            shift_reg <= step_value;
            count     <= count - 5'd1;
        end
    end

`endif

endmodule

// File: rtl/alu_execute_stage.sv
// ALU execute stage: adder/compare/logic ops complete in one cycle, shifts go
// through alu_shift_unit. Results sit in a one-entry output register behind a
// valid/ready handshake. Build option ALU_FAST_SHIFT_EN selects the
// single-cycle barrel shifter; without it shifts take shamt cycles.
module alu_execute_stage
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic              clk,
    input  logic              rst,
    alu_execute_stage_if.slave bus,
    output logic              busy,
    output exec_state_e       state
);

    logic            accept;
    logic            is_shift;
    logic            sub_eff;
    logic [XLEN:0]   sum_full;
    logic            lt;
    logic [XLEN-1:0] calc_value;
    logic            need_iter;
    logic [XLEN-1:0] imm_value;
    logic [XLEN-1:0] step_value;
    logic            last_step;
    logic            start_shift;
    logic            load_now;
    logic            shift_done;
    logic [4:0]      rd_q;

    // Only accept when idle and the output register is empty or draining.
    assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_shift     = is_shift_op(bus.alu_control);

    // slt always subtracts, regardless of the decoder's sub flag.
    assign sub_eff  = bus.sub || (bus.alu_control == ALU_SLT);
    assign sum_full = {1'b0, bus.op_a} + {1'b0, bus.op_b ^ {XLEN{sub_eff}}}
                    + {{XLEN{1'b0}}, sub_eff};

    // Signed: differing signs decide directly, else the difference sign.
    // Unsigned: a borrow (no carry out) means a < b.
    assign lt = bus.cmp_unsigned ? !sum_full[XLEN]
              : (bus.op_a[XLEN-1] != bus.op_b[XLEN-1]) ? bus.op_a[XLEN-1]
              : sum_full[XLEN-1];

    assign start_shift = accept && is_shift && need_iter;
    assign load_now    = accept && !(is_shift && need_iter);
    assign shift_done  = (state == SHIFT) && last_step;

    alu_shift_unit #(.XLEN(XLEN)) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (start_shift),
        .advance    (state == SHIFT),
        .op         (bus.alu_control),
        .operand    (bus.op_a),
        .shamt      (bus.op_b[4:0]),
        .need_iter  (need_iter),
        .imm_value  (imm_value),
        .step_value (step_value),
        .last_step  (last_step)
    );

    // Single-cycle result selection.
    always_comb begin
        calc_value = sum_full[XLEN-1:0];
        case (bus.alu_control)
            ALU_ADD: calc_value = sum_full[XLEN-1:0];
            ALU_SLT: calc_value = {{(XLEN-1){1'b0}}, lt};
            ALU_AND: calc_value = bus.op_a & bus.op_b;
            ALU_OR:  calc_value = bus.op_a | bus.op_b;
            ALU_XOR: calc_value = bus.op_a ^ bus.op_b;
            default: calc_value = imm_value;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign busy = 1'b0;
`else
    assign busy = (state == SHIFT);
`endif

    // Execute FSM and output register; a new load wins over a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rd_q          <= 5'd0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b0;
            bus.rd_out    <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_shift) begin
                        state <= SHIFT;
                        rd_q  <= bus.rd_in;
                    end
                end
                SHIFT: begin
                    if (last_step) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (load_now) begin
                bus.out_valid <= 1'b1;
                bus.result    <= calc_value;
                bus.zero      <= (calc_value == '0);
                bus.rd_out    <= bus.rd_in;
            end else if (shift_done) begin
                bus.out_valid <= 1'b1;
                bus.result    <= step_value;
                bus.zero      <= (step_value == '0);
                bus.rd_out    <= rd_q;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule
